// File: rtl/arb8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotated priority search: first set req bit starting at ptr, wrapping mod 8.
module rr_pick8
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // 3-bit addition wraps naturally from 7 back to 0
      pos = ptr + IDX_W'(k);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with registered one-hot grant and ready handshake.
// Optional grant lock across handshakes when ARB8_LOCK_EN is defined.
module rr_arb8
  import arb8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
`ifdef ARB8_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] search_ptr;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             hs;
  logic             lock_en;
  logic             keep;

`ifdef ARB8_LOCK_EN
  assign lock_en = lock;
`else
  assign lock_en = 1'b0;
`endif

  assign hs   = (state_q == GRANT) && grant_ready;
  assign keep = hs && lock_en && req[win_q];

  // Searching from the current winner re-grants it when locked and still requesting.
  always_comb begin
    search_ptr = ptr_q;
    if (hs) begin
      search_ptr = keep ? win_q : (win_q + IDX_W'(1));
    end
  end

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (search_ptr),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_onehot;
          win_d   = pick_idx;
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (hs) begin
          if (!keep) ptr_d = search_ptr;
          if (pick_any) begin
            grant_d = pick_onehot;
            win_d   = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: directed scenarios plus randomized traffic
// against a behavioural round-robin model. Honours ARB8_LOCK_EN.
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       grant_ready;
  logic       lock_s;
  logic [7:0] grant;
  logic       grant_valid;

`ifdef ARB8_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Model state: who holds the grant, and where the next search starts.
  bit m_valid;
  int m_w;
  int m_ptr;

  always #5 clk = ~clk;

  rr_arb8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant_ready(grant_ready),
`ifdef ARB8_LOCK_EN
    .lock       (lock_s),
`endif
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_w] = 1'b1;
    return g;
  endfunction

  task automatic model_edge();
    int w;
    if (!m_valid) begin
      w = first_req(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_w     = w;
      end
    end else if (grant_ready) begin
      if (!(LockEn && lock_s && req[m_w])) begin
        m_ptr = (m_w + 1) % 8;
        w     = first_req(req, m_ptr);
        if (w >= 0) m_w = w;
        else m_valid = 1'b0;
      end
    end
  endtask

  // Called just after a falling edge: drive, clock, then check mid-low phase.
  task automatic step(input logic [7:0] r, input logic rdy, input logic lk);
    req         = r;
    grant_ready = rdy;
    lock_s      = lk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("grant", {24'h0, grant}, {24'h0, m_grant()});
    check("valid", {31'h0, grant_valid}, {31'h0, m_valid});
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_ptr   = 0;
    m_w     = 0;
    #2;
    check("rst_grant", {24'h0, grant}, 32'h0);
    check("rst_valid", {31'h0, grant_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req         = 8'h00;
    grant_ready = 1'b0;
    lock_s      = 1'b0;
    do_reset();

    // Two requesters alternate
    step(8'h81, 1'b1, 1'b0); check("alt0", {24'h0, grant}, 32'h01);
    step(8'h81, 1'b1, 1'b0); check("alt1", {24'h0, grant}, 32'h80);
    step(8'h81, 1'b1, 1'b0); check("alt2", {24'h0, grant}, 32'h01);
    step(8'h81, 1'b1, 1'b0); check("alt3", {24'h0, grant}, 32'h80);

    // All requesting: walk and wrap
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      check("walk", {24'h0, grant}, 32'h1 << (i % 8));
    end

    // Hold while not ready, regardless of req changes
    do_reset();
    step(8'h04, 1'b0, 1'b0); check("hold_first", {24'h0, grant}, 32'h04);
    for (int i = 0; i < 3; i++) begin
      step(8'h10, 1'b0, 1'b0); check("hold", {24'h0, grant}, 32'h04);
    end
    step(8'h10, 1'b1, 1'b0); check("hold_next", {24'h0, grant}, 32'h10);

    // Sole requester re-granted, then drop to idle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'h20, 1'b1, 1'b0); check("solo", {24'h0, grant}, 32'h20);
    end
    step(8'h00, 1'b1, 1'b0);
    check("solo_idle_g", {24'h0, grant}, 32'h0);
    check("solo_idle_v", {31'h0, grant_valid}, 32'h0);

    // Asynchronous reset mid-grant
    do_reset();
    step(8'h40, 1'b0, 1'b0); check("pre_rst", {24'h0, grant}, 32'h40);
    #2;
    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_ptr   = 0;
    #1;
    check("async_v", {31'h0, grant_valid}, 32'h0);
    check("async_g", {24'h0, grant}, 32'h0);
    req = 8'hC0;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hC0, 1'b0, 1'b0); check("post_rst", {24'h0, grant}, 32'h40);

`ifdef ARB8_LOCK_EN
    do_reset();
    step(8'h0A, 1'b1, 1'b1); check("lock0", {24'h0, grant}, 32'h02);
    step(8'h0A, 1'b1, 1'b1); check("lock1", {24'h0, grant}, 32'h02);
    step(8'h0A, 1'b1, 1'b1); check("lock2", {24'h0, grant}, 32'h02);
    step(8'h0A, 1'b1, 1'b0); check("unlock", {24'h0, grant}, 32'h08);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      check("onehot0", {31'h0, $onehot0(grant)}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
